uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
// Round-robin arbiter/sequencer sharing one UART transmitter between NREQ
// byte producers. Bytes are accepted over a valid/ready handshake, loaded
// into the transmitter through tx_load/tx_din, and paced on tx_te. A
// multi-byte message keeps the grant until its last byte.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   req_valid    - per-requester byte available
//   req_data     - byte for requester i in bits [8i+7:8i]
//   req_last     - byte is the last of its message
//   req_ready    - one-hot accept strobe (IDLE with tx_te=1 only)
//   req_en       - per-requester enable mask for new arbitration
//   tx_te        - transmitter TDR-empty flag (1 = empty)
//   tx_load      - one-cycle load strobe to the transmitter
//   tx_din       - byte presented to the transmitter
//   grant_id     - current or last granted requester
//   locked       - message in progress, grant held
//   busy         - not IDLE, or locked
//   err_timeout  - sticky flag: tx_te did not fall after a load
//   err_clr      - clears err_timeout (a same-cycle timeout wins)
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_en,
    input  logic              tx_te,
    output logic              tx_load,
    output logic [7:0]        tx_din,
    output logic [2:0]        grant_id,
    output logic              locked,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACK
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2:0]      r_ptr;
    logic [2:0]      r_grant;
    logic            r_locked;
    logic [7:0]      r_din;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [2:0]      w_gnt;
    logic [7:0]      w_data;
    logic            w_last;
    logic            w_accept;
    logic            w_timeout;
    logic [2:0]      w_ptr_inc;

    // Arbitration. Round-robin is done as two ordered passes (indices at or
    // above the pointer, then below it) so every select uses a loop-constant
    // index and no modulo arithmetic is needed.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_data  = '0;
        w_last  = 1'b0;
        w_elig  = req_valid & req_en;

        if (r_locked) begin
            // Owner keeps the grant; its enable bit is deliberately ignored.
            w_gnt = r_grant;
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (3'(j) == r_grant) begin
                    w_found = req_valid[j];
                end
            end
        end else begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!w_found && (j >= 32'(r_ptr)) && w_elig[j]) begin
                    w_found = 1'b1;
                    w_gnt   = 3'(j);
                end
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!w_found && (j < 32'(r_ptr)) && w_elig[j]) begin
                    w_found = 1'b1;
                    w_gnt   = 3'(j);
                end
            end
        end

        for (int unsigned j = 0; j < NREQ; j++) begin
            if (3'(j) == w_gnt) begin
                w_data = req_data[8*j +: 8];
                w_last = req_last[j];
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && tx_te && w_found;
    assign w_timeout = (r_state == S_ACK) && tx_te && (r_cnt == CW'(TIMEOUT - 1));
    assign w_ptr_inc = (w_gnt == 3'(NREQ - 1)) ? 3'd0 : (w_gnt + 3'd1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LOAD;
            S_LOAD: w_next = S_ACK;
            S_ACK: begin
                if (!tx_te || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            r_grant  <= '0;
            r_locked <= 1'b0;
            r_din    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_din    <= w_data;
                r_grant  <= w_gnt;
                r_locked <= ~w_last;
                if (w_last) begin
                    r_ptr <= w_ptr_inc;
                end
            end

            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACK) && tx_te && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Timeout abandons the message so other requesters are not starved.
            if (w_timeout) begin
                r_locked <= 1'b0;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (w_accept && (3'(j) == w_gnt)) begin
                req_ready[j] = 1'b1;
            end
        end
        tx_load     = (r_state == S_LOAD);
        tx_din      = r_din;
        grant_id    = r_grant;
        locked      = r_locked;
        busy        = (r_state != S_IDLE) || r_locked;
        err_timeout = r_err;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter (NREQ=4, TIMEOUT=16). Producers replay per-
// requester byte lists; expected {locked, grant_id, tx_din} per load are
// queued by hand and checked by a monitor whenever tx_load is seen.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_en;
    logic         tx_te;
    logic         tx_load;
    logic [7:0]   tx_din;
    logic [2:0]   grant_id;
    logic         locked;
    logic         busy;
    logic         err_timeout;
    logic         err_clr;

    uart_tx_arbiter #(
        .NREQ    (N),
        .TIMEOUT (16),
        .CW      (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .req_en      (req_en),
        .tx_te       (tx_te),
        .tx_load     (tx_load),
        .tx_din      (tx_din),
        .grant_id    (grant_id),
        .locked      (locked),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Producer byte lists
    logic [7:0] pdata [N][16];
    logic       plast [N][16];
    int         pgap  [N][16];
    int         pidx  [N];
    int         pcnt  [N];
    int         pgapc [N];
    logic [N-1:0] fire = '0;
    logic       model_en;

    // Scoreboard: {locked, grant_id[2:0], tx_din[7:0]}
    logic [11:0] sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ld(input int r, input logic [7:0] d, input logic l, input int gap);
        pdata[r][pcnt[r]] = d;
        plast[r][pcnt[r]] = l;
        pgap[r][pcnt[r]]  = gap;
        pcnt[r]++;
    endtask

    task automatic expect_load(input logic l, input logic [2:0] g, input logic [7:0] d);
        sbq.push_back({l, g, d});
    endtask

    task automatic clear_producers();
        for (int i = 0; i < N; i++) begin
            pidx[i]  = 0;
            pcnt[i]  = 0;
            pgapc[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_producers();
        sbq.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_load(input string name);
        bit seen = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx_load) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: tx_load not seen within 60 cycles", name);
        end
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int k = 0; k < 600; k++) begin
            done = 1;
            for (int i = 0; i < N; i++) if (pidx[i] < pcnt[i]) done = 0;
            if (sbq.size() != 0 || busy || !tx_te) done = 0;
            if (done) break;
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: not drained, %0d loads still expected, busy=%b", name, sbq.size(), busy);
        end
    endtask

    // Capture handshakes on the active edge (pre-update values).
    always @(posedge clk) fire <= reset ? '0 : (req_ready & req_valid);

    // Producers: advance on accepted bytes, drive the next byte each negedge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    pgapc[i] = pgap[i][pidx[i]];
                    pidx[i]++;
                end else if (pgapc[i] > 0) begin
                    pgapc[i]--;
                end
                if (pidx[i] < pcnt[i] && pgapc[i] == 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = pdata[i][pidx[i]];
                    req_last[i]         = plast[i][pidx[i]];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Transmitter model: TE falls shortly after a load and stays low 2 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (model_en && tx_load) begin
                tx_te = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                tx_te = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (tx_load) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_load", {20'h0, locked, grant_id, tx_din}, 32'hFFFFFFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("load{locked,grant,din}", {20'h0, locked, grant_id, tx_din}, {20'h0, e});
                end
            end
            if (!reset && (req_ready != '0)) begin
                chk("ready_onehot", {31'h0, $onehot(req_ready)}, 32'd1);
                chk("ready_needs_te", {31'h0, tx_te}, 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        req_en    = '1;
        tx_te     = 1'b1;
        err_clr   = 1'b0;
        model_en  = 1'b1;
        clear_producers();
        do_reset();

        // Reset values
        tick();
        chk("rst_ready", {28'h0, req_ready}, 32'h0);
        chk("rst_tx_load", {31'h0, tx_load}, 32'h0);
        chk("rst_tx_din", {24'h0, tx_din}, 32'h0);
        chk("rst_grant", {29'h0, grant_id}, 32'h0);
        chk("rst_locked", {31'h0, locked}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err_timeout}, 32'h0);

        // 1: single byte from req0
        ld(0, 8'h55, 1'b1, 0);
        expect_load(1'b0, 3'd0, 8'h55);
        tick();
        chk("t1_ready", {28'h0, req_ready}, 32'h1);
        tick();
        chk("t1_tx_load", {31'h0, tx_load}, 32'h1);
        chk("t1_tx_din", {24'h0, tx_din}, 32'h55);
        wait_done("t1_done");
        chk("t1_busy", {31'h0, busy}, 32'h0);

        // 2: all four valid, round-robin 0,1,2,3,0
        do_reset();
        ld(0, 8'hA0, 1'b1, 0);
        ld(1, 8'hA1, 1'b1, 0);
        ld(2, 8'hA2, 1'b1, 0);
        ld(3, 8'hA3, 1'b1, 0);
        ld(0, 8'hA4, 1'b1, 0);
        expect_load(1'b0, 3'd0, 8'hA0);
        expect_load(1'b0, 3'd1, 8'hA1);
        expect_load(1'b0, 3'd2, 8'hA2);
        expect_load(1'b0, 3'd3, 8'hA3);
        expect_load(1'b0, 3'd0, 8'hA4);
        wait_done("t2_done");

        // 3: req1 three-byte message stays contiguous, then req2, then wrap to req0
        do_reset();
        ld(0, 8'hC0, 1'b1, 0);
        ld(1, 8'hB0, 1'b0, 0);
        ld(1, 8'hB1, 1'b0, 0);
        ld(1, 8'hB2, 1'b1, 0);
        ld(2, 8'hD0, 1'b1, 0);
        ld(0, 8'hC1, 1'b1, 0);
        expect_load(1'b0, 3'd0, 8'hC0);
        expect_load(1'b1, 3'd1, 8'hB0);
        expect_load(1'b1, 3'd1, 8'hB1);
        expect_load(1'b0, 3'd1, 8'hB2);
        expect_load(1'b0, 3'd2, 8'hD0);
        expect_load(1'b0, 3'd0, 8'hC1);
        wait_done("t3_done");

        // 4: locked owner pauses 20 cycles with its enable dropped; lock holds
        do_reset();
        ld(0, 8'hE0, 1'b0, 20);
        ld(0, 8'hE1, 1'b1, 0);
        ld(1, 8'hF0, 1'b1, 0);
        ld(2, 8'hF2, 1'b1, 0);
        expect_load(1'b1, 3'd0, 8'hE0);
        expect_load(1'b0, 3'd0, 8'hE1);
        expect_load(1'b0, 3'd1, 8'hF0);
        expect_load(1'b0, 3'd2, 8'hF2);
        wait_load("t4_first_load");
        req_en = 4'b1110;
        repeat (10) tick();
        chk("t4_locked_hold", {31'h0, locked}, 32'h1);
        chk("t4_busy_hold", {31'h0, busy}, 32'h1);
        chk("t4_no_ready", {28'h0, req_ready}, 32'h0);
        wait_done("t4_done");
        req_en = '1;

        // 5: tx_te stuck high -> timeout after 16 ACK cycles
        do_reset();
        model_en = 1'b0;
        ld(3, 8'h90, 1'b0, 0);
        expect_load(1'b1, 3'd3, 8'h90);
        wait_load("t5_load");
        repeat (16) tick();
        chk("t5_err_before", {31'h0, err_timeout}, 32'h0);
        chk("t5_locked_before", {31'h0, locked}, 32'h1);
        tick();
        chk("t5_err_set", {31'h0, err_timeout}, 32'h1);
        chk("t5_lock_released", {31'h0, locked}, 32'h0);
        chk("t5_busy_idle", {31'h0, busy}, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_err_cleared", {31'h0, err_timeout}, 32'h0);
        ld(3, 8'h91, 1'b1, 0);
        expect_load(1'b0, 3'd3, 8'h91);
        wait_load("t5_load2");
        repeat (16) tick();
        chk("t5_err_before2", {31'h0, err_timeout}, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_set_wins", {31'h0, err_timeout}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_err_cleared2", {31'h0, err_timeout}, 32'h0);
        model_en = 1'b1;
        wait_done("t5_done");

        // 6: reset during the LOAD cycle of a locked byte; pointer returns to 0
        do_reset();
        ld(2, 8'h70, 1'b1, 0);
        ld(2, 8'h71, 1'b0, 0);
        expect_load(1'b0, 3'd2, 8'h70);
        expect_load(1'b1, 3'd2, 8'h71);
        begin
            bit seen = 0;
            for (int k = 0; k < 60; k++) begin
                tick();
                if (tx_load && tx_din == 8'h71) begin
                    seen = 1;
                    break;
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL t6_second_load: not seen within 60 cycles");
            end
        end
        reset = 1'b1;
        clear_producers();
        tick();
        chk("t6_tx_load", {31'h0, tx_load}, 32'h0);
        chk("t6_tx_din", {24'h0, tx_din}, 32'h0);
        chk("t6_grant", {29'h0, grant_id}, 32'h0);
        chk("t6_locked", {31'h0, locked}, 32'h0);
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_err", {31'h0, err_timeout}, 32'h0);
        tick();
        reset = 1'b0;
        ld(1, 8'h61, 1'b1, 0);
        ld(3, 8'h63, 1'b1, 0);
        expect_load(1'b0, 3'd1, 8'h61);
        expect_load(1'b0, 3'd3, 8'h63);
        wait_done("t6_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
